axis_sync_fifo_param: RTL

//  Parametrised single-clock AXI-Stream FIFO; successor to the fixed 256-bit sync FIFO wrapper.

---
 rtl/axis_sync_fifo_param_if.sv | 17 +
 rtl/axis_sync_fifo_param.sv | 106 ++++++++++
 2 files changed

// File: rtl/axis_sync_fifo_param_if.sv
// AXI-Stream handshake bundle for axis_sync_fifo_param; tlast present when AXIS_FIFO_TLAST_EN is defined.
interface axis_sync_fifo_param_if #(
  parameter int unsigned DATA_W = 256
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
`ifdef AXIS_FIFO_TLAST_EN
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
`else
  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
`endif
endinterface

// File: rtl/axis_sync_fifo_param.sv
// Single-clock AXI-Stream FIFO: DEPTH-1 entry memory plus a registered FWFT output stage.
// Optional tlast sideband enabled by defining AXIS_FIFO_TLAST_EN.
module axis_sync_fifo_param #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AF_TH      = 12,
  parameter int unsigned AE_TH      = 2
) (
  input  logic                     axis_clk,
  input  logic                     rst,
  axis_sync_fifo_param_if.slave    s_axis,
  axis_sync_fifo_param_if.master   m_axis,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned MEM_DEPTH = DEPTH - 1;
  localparam int unsigned PTR_W     = DEPTH_LOG2;
  localparam int unsigned LVL_W     = DEPTH_LOG2 + 1;
`ifdef AXIS_FIFO_TLAST_EN
  localparam int unsigned ENT_W     = DATA_W + 1;
`else
  localparam int unsigned ENT_W     = DATA_W;
`endif

  logic [ENT_W-1:0] mem [MEM_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_d;
  logic             tready_q;
  logic             out_valid_q, out_valid_d;
  logic [ENT_W-1:0] out_q, out_d;

  logic             push_c, pop_c, load_c, mem_rd_c, mem_wr_c;
  logic [LVL_W-1:0] mem_cnt_c;
  logic [ENT_W-1:0] s_entry_c;

  // Pointers wrap modulo the memory depth, which is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef AXIS_FIFO_TLAST_EN
  assign s_entry_c = {s_axis.tlast, s_axis.tdata};
  assign m_axis.tlast = out_q[DATA_W];
`else
  assign s_entry_c = s_axis.tdata;
`endif

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_q[DATA_W-1:0];

  // Next-state: output stage refills from memory, or straight from the input when memory is empty.
  always_comb begin
    push_c      = s_axis.tvalid && tready_q;
    pop_c       = out_valid_q && m_axis.tready;
    load_c      = !out_valid_q || pop_c;
    mem_cnt_c   = level - LVL_W'(out_valid_q);
    mem_rd_c    = load_c && (mem_cnt_c != '0);
    mem_wr_c    = push_c && !(load_c && (mem_cnt_c == '0));
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (mem_rd_c) begin
      out_valid_d = 1'b1;
      out_d       = mem[rd_ptr_q];
    end else if (load_c) begin
      out_valid_d = push_c;
      if (push_c) out_d = s_entry_c;
    end
    rd_ptr_d = mem_rd_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = mem_wr_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    level_d  = level + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  always_ff @(posedge axis_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level        <= '0;
      tready_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level        <= level_d;
      tready_q     <= level_d < LVL_W'(DEPTH);
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      almost_full  <= level_d >= LVL_W'(AF_TH);
      almost_empty <= level_d <= LVL_W'(AE_TH);
    end
  end

  // Storage array carries no reset; validity is tracked by level.
  always_ff @(posedge axis_clk) begin
    if (mem_wr_c) mem[wr_ptr_q] <= s_entry_c;
  end

endmodule
